// File: rtl/my_d_ff_pkg.sv
// Shared definitions for the my_d_ff register / delay-line primitive.
// This package holds the parameter limits and the reset-value type, plus
// helpers that the top level uses to check its parameters at elaboration.
package my_d_ff_pkg;

  // Widest data path supported. This also sets the storage width of the
  // reset-value parameter.
  localparam int DFF_MAX_WIDTH  = 64;

  // Longest supported cascade of stages.
  localparam int DFF_MAX_STAGES = 16;

  // Reset values are carried at full width and cut down to WIDTH at each
  // instance. A caller can then pass a literal of any size.
  typedef logic [DFF_MAX_WIDTH-1:0] dff_rst_val_t;

  // Default reset constant: every stage clears to zero.
  localparam dff_rst_val_t DFF_DEFAULT_RST_VAL = '0;

  // True when every set bit of val lies inside the low width bits.
  // Any set bit above that would be lost when val is cut to width.
  function automatic bit rst_val_fits(input dff_rst_val_t val, input int width);
    if (width >= DFF_MAX_WIDTH) begin
      return 1'b1;
    end
    return (val >> width) == '0;
  endfunction

  // Keeps only the low width bits of val, for use where a full-width
  // copy of the reset value is handy.
  function automatic dff_rst_val_t rst_val_trunc(input dff_rst_val_t val, input int width);
    dff_rst_val_t mask;
    if (width >= DFF_MAX_WIDTH) begin
      mask = '1;
    end else begin
      mask = (dff_rst_val_t'(1) << width) - dff_rst_val_t'(1);
    end
    return val & mask;
  endfunction

endpackage : my_d_ff_pkg

// File: rtl/my_d_ff_stage.sv
// One WIDTH-bit register stage with a synchronous active-low reset.
// The delay line in my_d_ff is built by chaining these stages.
module my_d_ff_stage
  import my_d_ff_pkg::*;
#(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_1,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // Next state: the stage captures its input on every edge. There is no
  // enable, and X/Z passes through unchanged.
  always_comb begin
    data_d = d;
  end

  // Storage: reset is sampled only on the clock edge and wins over data.
  always_ff @(posedge clk) begin
    if (!rst_1) begin
      data_q <= RST_VAL;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule : my_d_ff_stage

// File: rtl/my_d_ff.sv
// Parameterizable D flip-flop / delay line. STAGES identical WIDTH-bit
// registers are cascaded from d to q, and all of them reset together to
// RST_VAL on a synchronous active-low reset. q always comes from the last
// stage, so there is never a combinational path from d to q.
module my_d_ff
  import my_d_ff_pkg::*;
#(
  parameter int           WIDTH   = 1,
  parameter int           STAGES  = 1,
  parameter dff_rst_val_t RST_VAL = DFF_DEFAULT_RST_VAL
) (
  output logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  input  logic             clk,
  input  logic             rst_1
);

  // The reset value cut down to the data width. Any bits above WIDTH are
  // dropped here, and the elaboration check below warns about them.
  localparam logic [WIDTH-1:0] RST_VAL_W = WIDTH'(RST_VAL);

  // Elaboration-time parameter checks.
  if (WIDTH < 1) begin : g_bad_width
    $fatal(1, "my_d_ff: WIDTH must be at least 1");
  end

  if (STAGES < 1) begin : g_bad_stages
    $fatal(1, "my_d_ff: STAGES must be at least 1");
  end

  if (!rst_val_fits(RST_VAL, WIDTH)) begin : g_rst_val_trunc
    $warning("my_d_ff: RST_VAL is wider than WIDTH and is truncated");
  end

  // Output of each stage. Entry STAGES-1 is the visible q.
  logic [WIDTH-1:0] stage_q [STAGES];

  // Stage chain: stage 0 samples d, and every later stage samples the one
  // before it. All stages share the clock and reset, so a reset clears
  // all data in flight on the same edge.
  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    logic [WIDTH-1:0] stage_in;

    if (gi == 0) begin : g_first
      assign stage_in = d;
    end else begin : g_chain
      assign stage_in = stage_q[gi-1];
    end

    my_d_ff_stage #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL_W)
    ) u_stage (
      .clk   (clk),
      .rst_1 (rst_1),
      .d     (stage_in),
      .q     (stage_q[gi])
    );
  end

  assign q = stage_q[STAGES-1];

endmodule : my_d_ff

// File: tb/tb_my_d_ff.sv
// Scoreboard bench for my_d_ff. It drives two instances: the default
// 1-bit single-stage flop, and an 8-bit, 3-stage pipeline that resets
// to A5. The stimulus process pushes the hand-computed value expected
// after each edge, and a separate monitor pops and checks it just after
// that edge.
module tb_my_d_ff;

  typedef struct packed {
    logic       sel;   // 0: default flop, 1: pipeline
    logic [7:0] exp;
  } exp_t;

  logic       clk;
  logic       d0;
  logic       rst0;
  logic       q0;
  logic       qn0;
  logic [7:0] d1;
  logic       rst1;
  logic [7:0] q1;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_tests;
  int    n_fail;

  my_d_ff u_dut0 (
    .q     (q0),
    .d     (d0),
    .clk   (clk),
    .rst_1 (rst0)
  );

  my_d_ff #(
    .WIDTH   (8),
    .STAGES  (3),
    .RST_VAL (64'hA5)
  ) u_dut1 (
    .q     (q1),
    .d     (d1),
    .clk   (clk),
    .rst_1 (rst1)
  );

  // External inverter that produces the complement output.
  assign qn0 = ~q0;

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Drives inputs at the falling edge. Each expected value applies to the
  // rising edge that follows.
  task automatic step0(input logic d, input logic r, input logic e, input string nm);
    exp_t x;
    @(negedge clk);
    d0   = d;
    rst0 = r;
    x.sel = 1'b0;
    x.exp = {7'd0, e};
    exp_q.push_back(x);
    name_q.push_back(nm);
  endtask

  task automatic step1(input logic [7:0] d, input logic r, input logic [7:0] e, input string nm);
    exp_t x;
    @(negedge clk);
    d1   = d;
    rst1 = r;
    x.sel = 1'b1;
    x.exp = e;
    exp_q.push_back(x);
    name_q.push_back(nm);
  endtask

  // Monitor: checks outputs 2 units after each rising edge, once for
  // every queued expectation.
  initial begin
    exp_t  x;
    string nm;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
        x  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (x.sel == 1'b0) begin
          n_tests++;
          if (q0 !== x.exp[0]) begin
            n_fail++;
            $display("[TB] FAIL %s q: got %b expected %b", nm, q0, x.exp[0]);
          end else begin
            $display("[TB] ok   %s q=%b", nm, q0);
          end
          n_tests++;
          if (qn0 !== ~x.exp[0]) begin
            n_fail++;
            $display("[TB] FAIL %s qn: got %b expected %b", nm, qn0, ~x.exp[0]);
          end
        end else begin
          n_tests++;
          if (q1 !== x.exp) begin
            n_fail++;
            $display("[TB] FAIL %s q: got %h expected %h", nm, q1, x.exp);
          end else begin
            $display("[TB] ok   %s q=%h", nm, q1);
          end
        end
      end
    end
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    d0   = 1'b0;
    rst0 = 1'b0;
    d1   = 8'h00;
    rst1 = 1'b0;

    // Default flop: reset, release, then toggle tracking.
    step0(1'b1, 1'b0, 1'b0, "rst_edge1");
    step0(1'b1, 1'b0, 1'b0, "rst_edge2");
    step0(1'b1, 1'b1, 1'b1, "rst_release");
    step0(1'b1, 1'b1, 1'b1, "toggle0");
    step0(1'b0, 1'b1, 1'b0, "toggle1");
    step0(1'b1, 1'b1, 1'b1, "toggle2");
    step0(1'b1, 1'b1, 1'b1, "toggle3");
    step0(1'b0, 1'b1, 1'b0, "toggle4");

    // Pulse the reset between edges. It must be ignored.
    step0(1'b1, 1'b1, 1'b1, "pre_glitch");
    @(posedge clk);
    #5 rst0 = 1'b0;
    #4 rst0 = 1'b1;
    step0(1'b1, 1'b1, 1'b1, "glitch_ignored");
    step0(1'b1, 1'b0, 1'b0, "rst_held");
    step0(1'b1, 1'b1, 1'b1, "recover");

    // A data change on the same edge as the reset: reset wins.
    step0(1'b0, 1'b1, 1'b0, "pre_sim");
    step0(1'b1, 1'b0, 1'b0, "sim_rst_wins");
    step0(1'b1, 1'b1, 1'b1, "post_sim");

    // Pipeline: WIDTH=8, STAGES=3, RST_VAL=A5 (held in reset until now).
    step1(8'h00, 1'b0, 8'hA5, "pipe_rst");
    step1(8'h01, 1'b1, 8'hA5, "pipe_fill1");
    step1(8'h02, 1'b1, 8'hA5, "pipe_fill2");
    step1(8'h03, 1'b1, 8'h01, "pipe_out01");
    step1(8'h04, 1'b1, 8'h02, "pipe_out02");
    step1(8'h05, 1'b1, 8'h03, "pipe_out03");

    // Reset while 05/04/03 are in flight. No stale value may appear later.
    step1(8'h06, 1'b0, 8'hA5, "pipe_mid_rst");
    step1(8'h07, 1'b1, 8'hA5, "pipe_no_stale1");
    step1(8'h08, 1'b1, 8'hA5, "pipe_no_stale2");
    step1(8'h09, 1'b1, 8'h07, "pipe_out07");
    step1(8'h0A, 1'b1, 8'h08, "pipe_out08");
    step1(8'hFF, 1'b0, 8'hA5, "pipe_sim_rst_wins");
    step1(8'h11, 1'b1, 8'hA5, "pipe_post_sim");

    // Let the monitor drain. Any expectation left over is a failure.
    repeat (2) @(posedge clk);
    #5;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_my_d_ff
